id_ex_stage: RTL and testbench

ID/EX pipeline register of the five-stage RISC-V core, with integrated load-use hazard detection. Captures decoded control, operands and register addresses from ID each cycle and presents them to EX. The registered RS1/RS2/RD addresses and RegWrite drive the EX-stage forwarding unit. Handles stall, flush and bubble insertion, so that downstream stages only ever see either a valid instruction or an all-zero NOP.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUOp encodings, the ID/EX control bundle,
// its NOP value and the hard-wired zero register address.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t       CTRL_NOP = '0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags a load in EX whose
// destination is read by the instruction currently in ID.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);

    // RS2 is always compared: a spurious stall is harmless, a missed one is not.
    always_comb begin
        hazard_o = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != REG_ZERO) & id_valid_i &
                   ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush handling.
// Optional macro ID_EX_PERF_EN enables the bubble/flush performance counters;
// without it both counter ports read 0.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic            id_RegWrite_i,
    input  logic            id_MemtoReg_i,
    input  logic            id_MemRead_i,
    input  logic            id_MemWrite_i,
    input  logic            id_ALUSrc_i,
    input  logic [1:0]      id_ALUOp_i,
    input  logic [9:0]      id_funct_i,
    input  logic [XLEN-1:0] id_RS1data_i,
    input  logic [XLEN-1:0] id_RS2data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [4:0]      id_RS1addr_i,
    input  logic [4:0]      id_RS2addr_i,
    input  logic [4:0]      id_RDaddr_i,
    output logic            ex_valid_o,
    output logic            ex_RegWrite_o,
    output logic            ex_MemtoReg_o,
    output logic            ex_MemRead_o,
    output logic            ex_MemWrite_o,
    output logic            ex_ALUSrc_o,
    output logic [1:0]      ex_ALUOp_o,
    output logic [9:0]      ex_funct_o,
    output logic [XLEN-1:0] ex_RS1data_o,
    output logic [XLEN-1:0] ex_RS2data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [4:0]      ex_RS1addr_o,
    output logic [4:0]      ex_RS2addr_o,
    output logic [4:0]      ex_RDaddr_o,
    output logic            hazard_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [9:0]      funct;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
    } entry_t;

    entry_t ex_q;
    entry_t id_entry;
    entry_t bubble;
    logic   hazard;
    logic   insert_bubble;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ex_q.ctrl.mem_read),
        .ex_rd_addr_i  (ex_q.rd_addr),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_RS1addr_i),
        .id_rs2_addr_i (id_RS2addr_i),
        .hazard_o      (hazard)
    );

    // Assemble the incoming ID entry and the all-zero NOP entry.
    always_comb begin
        id_entry                 = '0;
        id_entry.valid           = id_valid_i;
        id_entry.ctrl.reg_write  = id_RegWrite_i;
        id_entry.ctrl.mem_to_reg = id_MemtoReg_i;
        id_entry.ctrl.mem_read   = id_MemRead_i;
        id_entry.ctrl.mem_write  = id_MemWrite_i;
        id_entry.ctrl.alu_src    = id_ALUSrc_i;
        id_entry.ctrl.alu_op     = alu_op_e'(id_ALUOp_i);
        id_entry.funct           = id_funct_i;
        id_entry.rs1_data        = id_RS1data_i;
        id_entry.rs2_data        = id_RS2data_i;
        id_entry.imm             = id_imm_i;
        id_entry.rs1_addr        = id_RS1addr_i;
        id_entry.rs2_addr        = id_RS2addr_i;
        id_entry.rd_addr         = id_RDaddr_i;
        bubble                   = '0;
        bubble.ctrl              = CTRL_NOP;
        insert_bubble            = flush_i | hazard | ~id_valid_i;
    end

    // Pipeline register: reset > hold > bubble (flush/load-use/invalid) > load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else if (!hold_i) begin
            ex_q <= insert_bubble ? bubble : id_entry;
        end
    end

    // Present the registered entry to EX.
    always_comb begin
        ex_valid_o    = ex_q.valid;
        ex_RegWrite_o = ex_q.ctrl.reg_write;
        ex_MemtoReg_o = ex_q.ctrl.mem_to_reg;
        ex_MemRead_o  = ex_q.ctrl.mem_read;
        ex_MemWrite_o = ex_q.ctrl.mem_write;
        ex_ALUSrc_o   = ex_q.ctrl.alu_src;
        ex_ALUOp_o    = ex_q.ctrl.alu_op;
        ex_funct_o    = ex_q.funct;
        ex_RS1data_o  = ex_q.rs1_data;
        ex_RS2data_o  = ex_q.rs2_data;
        ex_imm_o      = ex_q.imm;
        ex_RS1addr_o  = ex_q.rs1_addr;
        ex_RS2addr_o  = ex_q.rs2_addr;
        ex_RDaddr_o   = ex_q.rd_addr;
        hazard_o      = hazard;
    end

`ifdef ID_EX_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters; a flush coinciding with a load-use counts as a flush only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (!hold_i) begin
            if (flush_i) begin
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end else if (hazard) begin
                if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (CNT_W=4) against a behavioural model
// of the ID/EX register, load-use rule and saturating counters.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        as;
        logic [1:0]  op;
        logic [9:0]  funct;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
    } ent_t;

    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst, hold, flush;
    ent_t in;
    ent_t dut_ent;
    ent_t m;
    int   mb, mf;
    int   errors = 0;
    int   checks = 0;

    logic        ex_valid_o, ex_RegWrite_o, ex_MemtoReg_o, ex_MemRead_o, ex_MemWrite_o, ex_ALUSrc_o;
    logic [1:0]  ex_ALUOp_o;
    logic [9:0]  ex_funct_o;
    logic [31:0] ex_RS1data_o, ex_RS2data_o, ex_imm_o;
    logic [4:0]  ex_RS1addr_o, ex_RS2addr_o, ex_RDaddr_o;
    logic        hazard_o;
    logic [3:0]  bubble_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
        .id_valid_i(in.valid), .id_RegWrite_i(in.rw), .id_MemtoReg_i(in.m2r),
        .id_MemRead_i(in.mr), .id_MemWrite_i(in.mw), .id_ALUSrc_i(in.as),
        .id_ALUOp_i(in.op), .id_funct_i(in.funct),
        .id_RS1data_i(in.d1), .id_RS2data_i(in.d2), .id_imm_i(in.imm),
        .id_RS1addr_i(in.a1), .id_RS2addr_i(in.a2), .id_RDaddr_i(in.rd),
        .ex_valid_o(ex_valid_o), .ex_RegWrite_o(ex_RegWrite_o), .ex_MemtoReg_o(ex_MemtoReg_o),
        .ex_MemRead_o(ex_MemRead_o), .ex_MemWrite_o(ex_MemWrite_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .ex_ALUOp_o(ex_ALUOp_o), .ex_funct_o(ex_funct_o),
        .ex_RS1data_o(ex_RS1data_o), .ex_RS2data_o(ex_RS2data_o), .ex_imm_o(ex_imm_o),
        .ex_RS1addr_o(ex_RS1addr_o), .ex_RS2addr_o(ex_RS2addr_o), .ex_RDaddr_o(ex_RDaddr_o),
        .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    assign dut_ent = {ex_valid_o, ex_RegWrite_o, ex_MemtoReg_o, ex_MemRead_o, ex_MemWrite_o,
                      ex_ALUSrc_o, ex_ALUOp_o, ex_funct_o, ex_RS1data_o, ex_RS2data_o,
                      ex_imm_o, ex_RS1addr_o, ex_RS2addr_o, ex_RDaddr_o};

    // Reference: a load in EX whose nonzero destination is read by a valid ID instruction.
    function automatic logic model_hazard();
        return m.valid && m.mr && (m.rd != 5'd0) && in.valid && (m.rd == in.a1 || m.rd == in.a2);
    endfunction

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        logic hz;
        hz = model_hazard();
        if (rst) begin
            m = '0; mb = 0; mf = 0;
        end else if (!hold) begin
            if (flush) begin
                m = '0;
`ifdef ID_EX_PERF_EN
                if (mf < CMAX) mf++;
`endif
            end else if (hz) begin
                m = '0;
`ifdef ID_EX_PERF_EN
                if (mb < CMAX) mb++;
`endif
            end else if (!in.valid) begin
                m = '0;
            end else begin
                m = in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic mr,
                             input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
        in.valid = v; in.rw = rw; in.mr = mr; in.m2r = mr; in.mw = 1'b0;
        in.as = $urandom_range(0, 1); in.op = 2'($urandom_range(0, 3));
        in.funct = 10'($urandom); in.d1 = $urandom; in.d2 = $urandom; in.imm = $urandom;
        in.rd = rd; in.a1 = a1; in.a2 = a2;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        set_instr(1'b1, 1'b1, 1'b1, 5'd7, 5'd1, 5'd2);
        tick(); tick();
        checks++;
        if (dut_ent !== '0) begin errors++; $display("FAIL reset_entry got=%h exp=0", dut_ent); end
        checks++;
        if (bubble_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || hazard_o !== 1'b0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d/%b exp=0/0/0", bubble_cnt_o, flush_cnt_o, hazard_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        set_instr(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2);
        tick();
        checks++;
        if (ex_RDaddr_o !== 5'd3 || ex_RegWrite_o !== 1'b1 || ex_valid_o !== 1'b1) begin
            errors++; $display("FAIL add_load got rd=%0d rw=%b v=%b exp rd=3 rw=1 v=1", ex_RDaddr_o, ex_RegWrite_o, ex_valid_o);
        end
        checks++;
        if (dut_ent !== m) begin errors++; $display("FAIL add_entry got=%h exp=%h", dut_ent, m); end
    endtask

    task automatic test_load_use();
        set_instr(1'b1, 1'b1, 1'b1, 5'd5, 5'd9, 5'd10);
        tick();
        set_instr(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd11);
        #1;
        checks++;
        if (hazard_o !== 1'b1) begin errors++; $display("FAIL lu_hazard got=%b exp=1", hazard_o); end
        tick();
        checks++;
        if (dut_ent !== '0 || bubble_cnt_o !== 4'(mb)) begin
            errors++; $display("FAIL lu_bubble got=%h cnt=%0d exp=0 cnt=%0d", dut_ent, bubble_cnt_o, mb);
        end
        checks++;
        if (hazard_o !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", hazard_o); end
        tick();
        checks++;
        if (dut_ent !== m || ex_valid_o !== 1'b1 || ex_RS1addr_o !== 5'd5) begin
            errors++; $display("FAIL lu_consumer got=%h exp=%h", dut_ent, m);
        end
    endtask

    task automatic test_x0_and_rs2();
        set_instr(1'b1, 1'b1, 1'b1, 5'd0, 5'd3, 5'd4);
        tick();
        set_instr(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0);
        #1;
        checks++;
        if (hazard_o !== 1'b0) begin errors++; $display("FAIL x0_hazard got=%b exp=0", hazard_o); end
        set_instr(1'b1, 1'b1, 1'b1, 5'd5, 5'd3, 5'd4);
        tick();
        set_instr(1'b1, 1'b0, 1'b0, 5'd0, 5'd12, 5'd5);
        #1;
        checks++;
        if (hazard_o !== 1'b1) begin errors++; $display("FAIL rs2_hazard got=%b exp=1", hazard_o); end
        tick();
        checks++;
        if (dut_ent !== m) begin errors++; $display("FAIL rs2_bubble got=%h exp=%h", dut_ent, m); end
    endtask

    task automatic test_flush_hazard();
        set_instr(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd1);
        tick();
        set_instr(1'b1, 1'b1, 1'b0, 5'd2, 5'd5, 5'd6);
        flush = 1'b1;
        #1;
        checks++;
        if (hazard_o !== 1'b1) begin errors++; $display("FAIL fh_hazard got=%b exp=1", hazard_o); end
        tick();
        flush = 1'b0;
        checks++;
        if (dut_ent !== '0 || flush_cnt_o !== 4'(mf) || bubble_cnt_o !== 4'(mb)) begin
            errors++; $display("FAIL fh_count got=%h f=%0d b=%0d exp=0 f=%0d b=%0d",
                               dut_ent, flush_cnt_o, bubble_cnt_o, mf, mb);
        end
    endtask

    task automatic test_hold();
        set_instr(1'b1, 1'b1, 1'b1, 5'd9, 5'd1, 5'd2);
        tick();
        hold = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 1'b1, 1'b0, 5'(i + 1), 5'd9, 5'd3);
            #1;
            checks++;
            if (hazard_o !== 1'b1) begin errors++; $display("FAIL hold_hazard[%0d] got=%b exp=1", i, hazard_o); end
            tick();
            checks++;
            if (dut_ent !== m || bubble_cnt_o !== 4'(mb) || flush_cnt_o !== 4'(mf) || ex_RDaddr_o !== 5'd9) begin
                errors++; $display("FAIL hold_stable[%0d] got=%h b=%0d f=%0d exp=%h b=%0d f=%0d",
                                   i, dut_ent, bubble_cnt_o, flush_cnt_o, m, mb, mf);
            end
        end
        hold = 1'b0; flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (hazard_o !== 1'b0 || dut_ent !== '0) begin
            errors++; $display("FAIL midreset got hz=%b ent=%h exp hz=0 ent=0", hazard_o, dut_ent);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_instr($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            in.mw = 1'($urandom);
            #1;
            checks++;
            if (hazard_o !== model_hazard()) begin
                errors++; $display("FAIL rnd_hazard[%0d] got=%b exp=%b", i, hazard_o, model_hazard());
            end
            tick();
            checks++;
            if (dut_ent !== m || bubble_cnt_o !== 4'(mb) || flush_cnt_o !== 4'(mf)) begin
                errors++; $display("FAIL rnd_state[%0d] got=%h b=%0d f=%0d exp=%h b=%0d f=%0d",
                                   i, dut_ent, bubble_cnt_o, flush_cnt_o, m, mb, mf);
            end
        end
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_sat;
`ifdef ID_EX_PERF_EN
        exp_sat = CMAX;
`else
        exp_sat = 0;
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_instr(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd2);
            tick();
            set_instr(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd7);
            tick();
            checks++;
            if (bubble_cnt_o !== 4'(mb)) begin
                errors++; $display("FAIL sat_bubble[%0d] got=%0d exp=%0d", i, bubble_cnt_o, mb);
            end
        end
        checks++;
        if (bubble_cnt_o !== 4'(exp_sat)) begin
            errors++; $display("FAIL sat_bubble_final got=%0d exp=%0d", bubble_cnt_o, exp_sat);
        end
        flush = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        flush = 1'b0;
        checks++;
        if (flush_cnt_o !== 4'(exp_sat) || bubble_cnt_o !== 4'(exp_sat)) begin
            errors++; $display("FAIL sat_flush_final got f=%0d b=%0d exp=%0d", flush_cnt_o, bubble_cnt_o, exp_sat);
        end
    endtask

    initial begin
        m = '0; mb = 0; mf = 0; in = '0;
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        #2;
        test_reset();
        test_add();
        test_load_use();
        test_x0_and_rs2();
        test_flush_hazard();
        test_hold();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
